// File: rtl/mm_exp_ctrl_pkg.sv
// Shared constants for the Montgomery exponentiation controller over q = 2^255 - 19.
// Montgomery radix is R = 2^255.
package mm_exp_ctrl_pkg;

  localparam int MM_DATA_W = 255;
  localparam int MM_EXP_W  = 255;
  localparam int CNT_W     = 8;

  localparam logic [MM_DATA_W-1:0] Q        = {MM_DATA_W{1'b1}} - 255'd18;
  localparam logic [MM_DATA_W-1:0] R_MOD_Q  = 255'd19;
  localparam logic [MM_DATA_W-1:0] R2_MOD_Q = 255'd361;

  // Newton iteration x <- x*(2 - m*x) doubles the number of correct low bits each step.
  function automatic logic [MM_DATA_W-1:0] calc_minus_inv(input logic [MM_DATA_W-1:0] m);
    logic [MM_DATA_W-1:0] x;
    x = m;
    for (int i = 0; i < 8; i++) begin
      x = x * (255'd2 - m * x);
    end
    return 255'd0 - x;
  endfunction

  localparam logic [MM_DATA_W-1:0] MINUS_Q_INV = calc_minus_inv(Q);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQR  = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mm_exp_ctrl_mm.sv
// Combinational Montgomery multiplier: z = x*y*2^-255 mod q, for x, y < q.
// A single conditional subtraction suffices because the REDC sum is below 2q.
module mm_exp_ctrl_mm
  import mm_exp_ctrl_pkg::*;
(
  input  logic [MM_DATA_W-1:0] x,
  input  logic [MM_DATA_W-1:0] y,
  output logic [MM_DATA_W-1:0] z
);

  logic [2*MM_DATA_W-1:0] t;
  logic [MM_DATA_W-1:0]   m;
  logic [2*MM_DATA_W:0]   u;
  logic [MM_DATA_W:0]     s;
  logic [MM_DATA_W:0]     d;

  // REDC: low half of u is zero by construction, so the high part is the quotient by R.
  always_comb begin
    t = {{MM_DATA_W{1'b0}}, x} * {{MM_DATA_W{1'b0}}, y};
    m = t[MM_DATA_W-1:0] * MINUS_Q_INV;
    u = {{(MM_DATA_W+1){1'b0}}, m} * {{(MM_DATA_W+1){1'b0}}, Q} + {1'b0, t};
    s = u[2*MM_DATA_W:MM_DATA_W];
    d = s - {1'b0, Q};
    if (d[MM_DATA_W]) begin
      z = s[MM_DATA_W-1:0];
    end else begin
      z = d[MM_DATA_W-1:0];
    end
  end

endmodule

// File: rtl/mm_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer issuing one Montgomery multiply per clock.
// Computes base^exp mod q with base and result in Montgomery form.
module mm_exp_ctrl
  import mm_exp_ctrl_pkg::*;
#(
  parameter int DATA_W = MM_DATA_W,
  parameter int EXP_W  = MM_EXP_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_base,
  input  logic [EXP_W-1:0]  i_exp,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_result,
  output logic              o_busy
);

  state_t             state;
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  base_r;
  logic [EXP_W-1:0]   exp_r;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  mm_y;
  logic [DATA_W-1:0]  mm_z;

  // Operand mux: only the second operand changes between squaring and multiplying.
  always_comb begin
    case (state)
      ST_MUL:  mm_y = base_r;
      default: mm_y = acc;
    endcase
  end

  mm_exp_ctrl_mm u_mm (
    .x (acc),
    .y (mm_y),
    .z (mm_z)
  );

  // Controller FSM with registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      acc         <= '0;
      base_r      <= '0;
      exp_r       <= '0;
      bit_cnt     <= '0;
      o_in_ready  <= 1'b1;
      o_out_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_result    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_in_valid && o_in_ready) begin
            base_r     <= i_base;
            exp_r      <= i_exp;
            acc        <= R_MOD_Q;
            bit_cnt    <= CNT_W'(EXP_W - 1);
            o_in_ready <= 1'b0;
            o_busy     <= 1'b1;
            state      <= ST_SQR;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SQR: begin
          acc <= mm_z;
          if (exp_r[bit_cnt]) begin
            state <= ST_MUL;
          end else if (bit_cnt == CNT_W'(0)) begin
            o_result    <= mm_z;
            o_out_valid <= 1'b1;
            state       <= ST_DONE;
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        ST_MUL: begin
          acc <= mm_z;
          if (bit_cnt == CNT_W'(0)) begin
            o_result    <= mm_z;
            o_out_valid <= 1'b1;
            state       <= ST_DONE;
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
            state   <= ST_SQR;
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            o_out_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_in_ready  <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            state <= ST_DONE;
          end
        end
        default: begin
          o_out_valid <= 1'b0;
          o_busy      <= 1'b0;
          o_in_ready  <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
